// File: rtl/uart_hex_display_scheduler.sv
// UART byte capture and 4-digit seven-segment scan scheduler for the Basys3 display.
// Optional activity dot on digit 0 is built when UART_DISP_ACTIVITY_DOT_EN is defined.
module uart_hex_display_scheduler #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter int unsigned ACT_CYCLES   = 10000000
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       clear,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   // ACT_CYCLES+1 must not wrap, or the hold counter width collapses
   if (REFRESH_DIV < 4 || BLANK_CYCLES >= REFRESH_DIV || ACT_CYCLES == 32'hFFFF_FFFF) begin : g_bad_params
      $error("uart_hex_display_scheduler: illegal REFRESH_DIV/BLANK_CYCLES/ACT_CYCLES");
   end

   logic [7:0]    byte1, byte0;
   logic [1:0]    fill;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    digit;
   logic          digit_ok;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   always_ff @(posedge clk_fpga) begin
      if (!reset) begin
         byte1 <= '0;
         byte0 <= '0;
         fill  <= '0;
      end else if (clear) begin
         byte1 <= '0;
         byte0 <= rx_valid ? rx_data : 8'h00;
         fill  <= rx_valid ? 2'd1 : 2'd0;
      end else if (rx_valid) begin
         byte1 <= byte0;
         byte0 <= rx_data;
         if (fill != 2'd2) fill <= fill + 2'd1;
      end
   end

   always_ff @(posedge clk_fpga) begin
      if (!reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == SLOT_LAST) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      digit    = byte0[3:0];
      digit_ok = (fill != 2'd0);
      case (idx)
         2'd0: digit = byte0[3:0];
         2'd1: digit = byte0[7:4];
         2'd2: digit = byte1[3:0];
         2'd3: digit = byte1[7:4];
         default: digit = byte0[3:0];
      endcase
      if (idx[1]) digit_ok = (fill == 2'd2);
   end

   always_comb begin
      an_nxt  = '1;
      seg_nxt = '1;
      if (cnt >= BLANK_END) begin
         an_nxt = ~(4'b0001 << idx);
         if (digit_ok) begin
            case (digit)
               4'h0: seg_nxt = 7'b1000000;
               4'h1: seg_nxt = 7'b1111001;
               4'h2: seg_nxt = 7'b0100100;
               4'h3: seg_nxt = 7'b0110000;
               4'h4: seg_nxt = 7'b0011001;
               4'h5: seg_nxt = 7'b0010010;
               4'h6: seg_nxt = 7'b0000010;
               4'h7: seg_nxt = 7'b1111000;
               4'h8: seg_nxt = 7'b0000000;
               4'h9: seg_nxt = 7'b0010000;
               4'hA: seg_nxt = 7'b0001000;
               4'hB: seg_nxt = 7'b0000011;
               4'hC: seg_nxt = 7'b1000110;
               4'hD: seg_nxt = 7'b0100001;
               4'hE: seg_nxt = 7'b0000110;
               4'hF: seg_nxt = 7'b0001110;
               default: seg_nxt = '1;
            endcase
         end
      end
   end

`ifdef UART_DISP_ACTIVITY_DOT_EN
   localparam int unsigned HW = $clog2(ACT_CYCLES + 1);
   logic [HW-1:0] hold;

   always_ff @(posedge clk_fpga) begin
      if (!reset)               hold <= '0;
      else if (rx_valid)        hold <= HW'(ACT_CYCLES);
      else if (hold != '0)      hold <= hold - 1'b1;
   end

   always_comb dp_nxt = !((hold != '0) && (an_nxt == 4'b1110));
`else
   always_comb dp_nxt = 1'b1;
`endif

   always_ff @(posedge clk_fpga) begin
      if (!reset) begin
         an  <= '1;
         seg <= '1;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_uart_hex_display_scheduler.sv
// Directed bench for uart_hex_display_scheduler: byte-queue display model checked every cycle,
// plus literal segment/anode expectations at key points of the scan.
module tb_uart_hex_display_scheduler;

   localparam int unsigned RD  = 8;
   localparam int unsigned BC  = 2;
   localparam int unsigned ACT = 20;

   logic       clk_fpga = 1'b0;
   logic       reset    = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       clear    = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int errors = 0;
   int checks = 0;

   uart_hex_display_scheduler #(
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC),
      .ACT_CYCLES  (ACT)
   ) dut (
      .clk_fpga(clk_fpga),
      .reset   (reset),
      .rx_valid(rx_valid),
      .rx_data (rx_data),
      .clear   (clear),
      .an      (an),
      .seg     (seg),
      .dp      (dp)
   );

   always #5 clk_fpga = ~clk_fpga;

   localparam logic [6:0] BLANK = 7'b1111111;
   logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: displayed bytes as a queue (oldest first), elapsed cycles since reset release
   logic [7:0] q[$];
   int         n = 0;
   int         hold_m = 0;
   logic [3:0] e_an  = 4'hF;
   logic [6:0] e_seg = BLANK;
   logic       e_dp  = 1'b1;
   bit         model_ok = 0;

   always @(posedge clk_fpga) begin
      int   pos, di;
      logic [7:0] b;
      if (!reset) begin
         e_an = 4'hF; e_seg = BLANK; e_dp = 1'b1;
         n = 0; q.delete(); hold_m = 0;
      end else begin
         pos = n % RD;
         di  = (n / RD) % 4;
         e_an = 4'hF; e_seg = BLANK;
         if (pos >= BC) begin
            e_an = ~(4'b0001 << di);
            if ((di >= 2 && q.size() == 2) || (di < 2 && q.size() >= 1)) begin
               b = (di >= 2) ? q[0] : q[q.size()-1];
               e_seg = dec[(di % 2 == 1) ? b[7:4] : b[3:0]];
            end
         end
`ifdef UART_DISP_ACTIVITY_DOT_EN
         e_dp = !(hold_m > 0 && e_an == 4'b1110);
         if (rx_valid) hold_m = ACT;
         else if (hold_m > 0) hold_m--;
`else
         e_dp = 1'b1;
`endif
         n++;
         if (clear) q.delete();
         if (rx_valid) begin
            q.push_back(rx_data);
            if (q.size() > 2) void'(q.pop_front());
         end
      end
      model_ok = 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_fpga) begin
      if (model_ok) begin
         chk("model_an", {28'd0, an}, {28'd0, e_an});
         chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
         chk("model_dp", {31'd0, dp}, {31'd0, e_dp});
      end
   end

   task automatic cycles(input int k);
      for (int i = 0; i < k; i++) @(negedge clk_fpga);
   endtask

   task automatic send(input logic [7:0] d, input logic clr);
      rx_data = d; rx_valid = 1'b1; clear = clr;
      @(negedge clk_fpga);
      rx_valid = 1'b0; clear = 1'b0;
      @(negedge clk_fpga);
   endtask

   task automatic wait_an(input string name, input logic [3:0] target);
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         if (an === target) found = 1;
         else @(negedge clk_fpga);
      end
      chk({name, "_reached"}, {31'd0, found}, 32'd1);
   endtask

   task automatic lit(input string name, input logic [3:0] target, input logic [6:0] exp_seg);
      wait_an(name, target);
      chk(name, {25'd0, seg}, {25'd0, exp_seg});
   endtask

   initial begin
      cycles(3);
      chk("rst_an", {28'd0, an}, 32'h0000000F);
      chk("rst_seg", {25'd0, seg}, 32'h0000007F);
      reset = 1'b1;
      cycles(3);
      chk("first_lit_an", {28'd0, an}, 32'h0000000E);
      chk("first_lit_seg", {25'd0, seg}, 32'h0000007F);
      cycles(40);

      send(8'h5A, 1'b0);
      lit("5A_d0", 4'b1110, 7'b0001000);
      lit("5A_d1", 4'b1101, 7'b0010010);
      lit("5A_d2", 4'b1011, BLANK);
      lit("5A_d3", 4'b0111, BLANK);

      send(8'h3C, 1'b0);
      send(8'h0E, 1'b0);
      lit("3C0E_d3", 4'b0111, 7'b0110000);
      lit("3C0E_d2", 4'b1011, 7'b1000110);
      lit("3C0E_d1", 4'b1101, 7'b1000000);
      lit("3C0E_d0", 4'b1110, 7'b0000110);

      send(8'hF1, 1'b0);
      lit("F1_d3", 4'b0111, 7'b1000000);
      lit("F1_d2", 4'b1011, 7'b0000110);
      lit("F1_d1", 4'b1101, 7'b0001110);
      lit("F1_d0", 4'b1110, 7'b1111001);

      send(8'h77, 1'b1);
      lit("clr77_d0", 4'b1110, 7'b1111000);
      lit("clr77_d1", 4'b1101, 7'b1111000);
      lit("clr77_d2", 4'b1011, BLANK);
      lit("clr77_d3", 4'b0111, BLANK);

      send(8'h12, 1'b0);
      cycles(8);
      send(8'h34, 1'b0);
      cycles(40);
`ifndef UART_DISP_ACTIVITY_DOT_EN
      chk("dp_idle", {31'd0, dp}, 32'd1);
`endif

      wait_an("mid_slot", 4'b1101);
      cycles(2);
      reset = 1'b0;
      @(negedge clk_fpga);
      chk("midrst_an", {28'd0, an}, 32'h0000000F);
      chk("midrst_seg", {25'd0, seg}, 32'h0000007F);
      reset = 1'b1;
      cycles(3);
      chk("restart_an", {28'd0, an}, 32'h0000000E);
      chk("restart_seg", {25'd0, seg}, 32'h0000007F);
      cycles(32);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
